uart_echo_fifo: RTL



---
 rtl/uart_echo_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: byte FIFO between UART receiver and transmitter, launching one frame at a time.
module uart_echo_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd_done,
  input  logic [DATA_W-1:0] data_rxd,
  input  logic              txd_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_q, rd_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                ovf_q, tmo_flag_q, tmo_flag_d;
  logic                wr_en, pop;
  assign full       = count_q == (ADDR_W+1)'(DEPTH);
  assign empty      = count_q == '0;
  // full is judged on the current count, so a pop on the same edge never frees room for the write
  assign wr_en      = rxd_done && !full;
  assign pop        = state_q == IDLE && !empty;
  assign tx_start   = state_q == LAUNCH;
  assign data_out   = data_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign tx_timeout = tmo_flag_q;
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      IDLE: begin
        state_d = pop ? LAUNCH : IDLE;
        data_d  = pop ? mem[rd_q] : data_q;
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        tmo_d   = '0;
      end
      WAIT_DONE: begin
        if (txd_done) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d    = IDLE;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_q + ADDR_W'(wr_en);
      rd_q       <= rd_q + ADDR_W'(pop);
      count_q    <= count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_q | (rxd_done & full);
      tmo_flag_q <= tmo_flag_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= data_rxd;
  end
endmodule
